// File: rtl/msgmii_cnvrxo_param.sv
// Receive-buffer to G/MII converter: it reads the frame buffer from a head pointer,
// optionally inserts a preamble and SFD, and splits bytes into nibbles at 10/100 speeds.
module msgmii_cnvrxo_param #(
    parameter int PTR_W     = 4,
    parameter int PRE_INS   = 0,
    parameter int PRE_LEN   = 7,
    parameter int NBL_LO1ST = 1
) (
    input  logic             rx_clki,
    input  logic             rx_clkirst_n,
    input  logic             rxcen,
    input  logic [1:0]       msgmii_speed,
    input  logic [7:0]       rxdlcl1,
    input  logic             rx_dvlcl1,
    input  logic             rx_erlcl1,
    input  logic             rxhdptrpls,
    input  logic [PTR_W-1:0] rxhdptr,
    output logic [7:0]       rxd,
    output logic             rx_dv,
    output logic             rx_er,
    output logic [PTR_W-1:0] rxrdptr,
    output logic             frm_act
);

    typedef enum logic [1:0] {IDLE, PRE, SFD, DATA} state_t;

    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(4);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [4:0]       PRE_G   = 5'(PRE_LEN - 1);
    localparam logic [4:0]       PRE_M   = 5'(2 * PRE_LEN - 1);

    state_t           state_reg, state_next;
    logic [2:0]       p_reg;
    logic             frstnbl_reg, frstnbl_next;
    logic [1:0]       spd_q_reg, spd_q_next;
    logic [4:0]       cnt_reg, cnt_next;
    logic [PTR_W-1:0] ptr_next;
    logic [7:0]       rxd_next;
    logic             dv_next, er_next;
    logic             hdedge, spd_mii, pre_last, sfd_last, byte_bnd, ptr_step;
    logic [3:0]       nbl_first, nbl_second;
    logic [7:0]       buf_byte;

    assign hdedge   = p_reg[1] & ~p_reg[2];
    assign spd_mii  = (spd_q_reg != 2'b10);
    assign pre_last = spd_mii ? (cnt_reg == PRE_M) : (cnt_reg == PRE_G);
    assign sfd_last = !spd_mii || (cnt_reg == 5'd1);
    // In MII a byte spans two cycles: boundaries on the first nibble, pointer steps after the second.
    assign byte_bnd = !spd_mii || frstnbl_reg;
    assign ptr_step = !spd_mii || !frstnbl_reg;
    assign frm_act  = (state_reg != IDLE);

    assign nbl_first  = (NBL_LO1ST != 0) ? rxdlcl1[3:0] : rxdlcl1[7:4];
    assign nbl_second = (NBL_LO1ST != 0) ? rxdlcl1[7:4] : rxdlcl1[3:0];
    assign buf_byte   = spd_mii ? {4'h0, (frstnbl_reg ? nbl_first : nbl_second)} : rxdlcl1;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        spd_q_next   = spd_q_reg;
        frstnbl_next = ~frstnbl_reg;
        ptr_next     = rxrdptr;
        rxd_next     = buf_byte;
        dv_next      = rx_dvlcl1;
        er_next      = rx_erlcl1;
        case (state_reg)
            IDLE: begin
                if (ptr_step) ptr_next = rxrdptr + PTR_ONE;
                if (hdedge && !rx_dvlcl1) begin
                    state_next   = (PRE_INS != 0) ? PRE : DATA;
                    spd_q_next   = msgmii_speed;
                    cnt_next     = '0;
                    frstnbl_next = 1'b1;
                    ptr_next     = (msgmii_speed == 2'b10) ? {rxhdptr[PTR_W-2:0], 1'b0} : rxhdptr;
                end
            end
            PRE: begin
                rxd_next = spd_mii ? 8'h05 : 8'h55;
                dv_next  = 1'b1;
                er_next  = 1'b0;
                if (pre_last) begin
                    state_next = SFD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            SFD: begin
                rxd_next = spd_mii ? (frstnbl_reg ? 8'h05 : 8'h0D) : 8'hD5;
                dv_next  = 1'b1;
                er_next  = 1'b0;
                if (sfd_last) begin
                    state_next = DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            default: begin
                if (ptr_step) ptr_next = rxrdptr + PTR_ONE;
                if (byte_bnd && !rx_dvlcl1) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge rx_clki or negedge rx_clkirst_n) begin
        if (!rx_clkirst_n) begin
            state_reg   <= IDLE;
            p_reg       <= '0;
            frstnbl_reg <= 1'b0;
            spd_q_reg   <= 2'b10;
            cnt_reg     <= '0;
            rxrdptr     <= PTR_RST;
            rxd         <= '0;
            rx_dv       <= 1'b0;
            rx_er       <= 1'b0;
        end else if (rxcen) begin
            state_reg   <= state_next;
            p_reg       <= {p_reg[1:0], rxhdptrpls};
            frstnbl_reg <= frstnbl_next;
            spd_q_reg   <= spd_q_next;
            cnt_reg     <= cnt_next;
            rxrdptr     <= ptr_next;
            rxd         <= rxd_next;
            rx_dv       <= dv_next;
            rx_er       <= er_next;
        end
    end

endmodule
